beam_mux_sched: RTL and testbench

- Frame-level scheduler in front of beam_mux.
- Owns beam_mux's dac_sel and gates the upstream modulator AXI-stream, so the DAC selection only changes on frame boundaries (after the beat with t_last).
- Rotates round-robin over a runtime mask of enabled DACs, dwelling a programmable number of frames on each, with guard cycles between switches.

---
 rtl/beam_mux_pkg.sv | 39 +++
 rtl/beam_rr_pick.sv | 35 +++
 rtl/beam_mux_sched.sv | 167 ++++++++++++++++
 tb/tb_beam_mux_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beam_mux_pkg.sv
// Shared types and helpers for the beam_mux frame scheduler and its bench model.
// next_enabled() is the single definition of the round-robin order.
package beam_mux_pkg;

  localparam int N_DACS_DEFAULT = 3;
  localparam int SEL_W_DEFAULT  = 2;
  localparam int MAX_DACS       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    RUN   = 2'd2
  } sched_state_t;

  // First set mask bit strictly after cur, wrapping modulo n_dacs.
  // Returns cur itself when it is the only enabled index.
  function automatic logic [1:0] next_enabled(input logic [MAX_DACS-1:0] mask,
                                              input logic [1:0]          cur,
                                              input int                  n_dacs);
    logic [1:0] nxt;
    logic [1:0] idx;
    logic       found;
    int         pos;
    nxt   = cur;
    found = 1'b0;
    for (int k = 1; k <= MAX_DACS; k++) begin
      if (k <= n_dacs && !found) begin
        pos = (int'(cur) + k) % n_dacs;
        idx = pos[1:0];
        if (mask[idx]) begin
          nxt   = idx;
          found = 1'b1;
        end
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/beam_rr_pick.sv
// Combinational round-robin picker: next enabled DAC after the current one,
// plus the lowest enabled DAC used when leaving IDLE.
module beam_rr_pick
  import beam_mux_pkg::*;
#(
  parameter int N_BEAM_MUX_DACS = N_DACS_DEFAULT,
  parameter int SEL_W           = SEL_W_DEFAULT
) (
  input  logic [N_BEAM_MUX_DACS-1:0] mask,
  input  logic [SEL_W-1:0]           cur,
  output logic [SEL_W-1:0]           next_idx,
  output logic [SEL_W-1:0]           first_idx,
  output logic                       cur_enabled,
  output logic                       any_enabled
);

  logic [MAX_DACS-1:0] mask_ext;
  logic [1:0]          cur_idx;
  logic [1:0]          last_idx;

  always_comb begin
    mask_ext                      = '0;
    mask_ext[N_BEAM_MUX_DACS-1:0] = mask;
  end

  assign cur_idx  = cur[1:0];
  assign last_idx = 2'(N_BEAM_MUX_DACS - 1);

  // Searching "after the last index" yields the lowest set bit.
  assign next_idx    = SEL_W'(next_enabled(mask_ext, cur_idx, N_BEAM_MUX_DACS));
  assign first_idx   = SEL_W'(next_enabled(mask_ext, last_idx, N_BEAM_MUX_DACS));
  assign cur_enabled = mask_ext[cur_idx];
  assign any_enabled = |mask;

endmodule

// File: rtl/beam_mux_sched.sv
// Frame-level scheduler in front of beam_mux: owns dac_sel, gates the modulator
// stream so the selection only changes between frames, with guard gaps on switches.
module beam_mux_sched
  import beam_mux_pkg::*;
#(
  parameter int N_BEAM_MUX_DACS = N_DACS_DEFAULT,
  parameter int SEL_W           = SEL_W_DEFAULT,
  parameter int CNT_W           = 8,
  parameter int GUARD_CYCLES    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_BEAM_MUX_DACS-1:0] dac_mask,
  input  logic [CNT_W-1:0]           dwell_frames,
  input  logic                       s_t_valid,
  input  logic                       s_t_last,
  output logic                       s_t_ready,
  input  logic                       mux_t_ready,
  output logic                       mux_t_valid,
  output logic [SEL_W-1:0]           dac_sel,
  output logic                       busy,
  output logic                       frame_done,
  output logic [CNT_W-1:0]           frame_cnt
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam sched_state_t AFTER_SELECT = (GUARD_CYCLES == 0) ? RUN : GUARD;

  sched_state_t     state_q, state_d;
  logic [SEL_W-1:0] dac_sel_q, dac_sel_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [GW-1:0]    guard_cnt_q, guard_cnt_d;
  logic             in_frame_q, in_frame_d;
  logic             stop_pending_q, stop_pending_d;
  logic             frame_done_q, frame_done_d;

  logic [SEL_W-1:0] next_idx;
  logic [SEL_W-1:0] first_idx;
  logic             cur_enabled;
  logic             any_enabled;

  logic             accept;
  logic             frame_end;
  logic [CNT_W-1:0] dwell_eff;
  logic [CNT_W:0]   cnt_next;
  logic             dwell_reached;

  beam_rr_pick #(
    .N_BEAM_MUX_DACS(N_BEAM_MUX_DACS),
    .SEL_W          (SEL_W)
  ) u_pick (
    .mask       (dac_mask),
    .cur        (dac_sel_q),
    .next_idx   (next_idx),
    .first_idx  (first_idx),
    .cur_enabled(cur_enabled),
    .any_enabled(any_enabled)
  );

  assign accept        = (state_q == RUN) && s_t_valid && mux_t_ready;
  assign frame_end     = accept && s_t_last;
  assign dwell_eff     = (dwell_frames == '0) ? CNT_W'(1) : dwell_frames;
  assign cnt_next      = {1'b0, frame_cnt_q} + 1'b1;
  assign dwell_reached = cnt_next >= {1'b0, dwell_eff};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      dac_sel_q      <= '0;
      frame_cnt_q    <= '0;
      guard_cnt_q    <= '0;
      in_frame_q     <= 1'b0;
      stop_pending_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      dac_sel_q      <= dac_sel_d;
      frame_cnt_q    <= frame_cnt_d;
      guard_cnt_q    <= guard_cnt_d;
      in_frame_q     <= in_frame_d;
      stop_pending_q <= stop_pending_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // dac_mask and dwell_frames are only consulted at IDLE exit and at frame end.
  always_comb begin
    state_d        = state_q;
    dac_sel_d      = dac_sel_q;
    frame_cnt_d    = frame_cnt_q;
    guard_cnt_d    = guard_cnt_q;
    in_frame_d     = in_frame_q;
    stop_pending_d = stop_pending_q;
    frame_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        in_frame_d     = 1'b0;
        stop_pending_d = 1'b0;
        guard_cnt_d    = '0;
        if (en && any_enabled) begin
          dac_sel_d   = first_idx;
          frame_cnt_d = '0;
          state_d     = AFTER_SELECT;
        end
      end

      GUARD: begin
        if (!en) begin
          guard_cnt_d = '0;
          state_d     = IDLE;
        end else if (guard_cnt_q == GUARD_LAST) begin
          guard_cnt_d = '0;
          state_d     = RUN;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (accept) begin
          in_frame_d = !s_t_last;
        end
        if (frame_end) begin
          frame_done_d   = 1'b1;
          stop_pending_d = 1'b0;
          if (!any_enabled || !en || stop_pending_q) begin
            frame_cnt_d = '0;
            state_d     = IDLE;
          end else if (dwell_reached || !cur_enabled) begin
            frame_cnt_d = '0;
            if (next_idx != dac_sel_q) begin
              dac_sel_d   = next_idx;
              guard_cnt_d = '0;
              state_d     = AFTER_SELECT;
            end
          end else begin
            frame_cnt_d = cnt_next[CNT_W-1:0];
          end
        end else if (!en) begin
          // A frame already under way is allowed to finish before stopping.
          if (in_frame_q || accept) begin
            stop_pending_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    s_t_ready   = (state_q == RUN) && mux_t_ready;
    mux_t_valid = (state_q == RUN) && s_t_valid;
    busy        = (state_q != IDLE);
    dac_sel     = dac_sel_q;
    frame_done  = frame_done_q;
    frame_cnt   = frame_cnt_q;
  end

endmodule

// File: tb/tb_beam_mux_sched.sv
// Directed bench for beam_mux_sched: a scoreboard of (dac, data) per beat and
// expected frame_cnt per completed frame, checked as beats reach the DAC side.
module tb_beam_mux_sched;

  localparam int N     = 3;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;
  localparam int GUARD = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [N-1:0]     dac_mask = '0;
  logic [CNT_W-1:0] dwell_frames = 8'd1;
  logic             s_t_valid = 1'b0;
  logic             s_t_last = 1'b0;
  logic             s_t_ready;
  logic             mux_t_ready = 1'b1;
  logic             mux_t_valid;
  logic [SEL_W-1:0] dac_sel;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;
  logic [15:0]      s_t_data = '0;

  typedef struct packed {
    logic [1:0]  dac;
    logic [15:0] data;
  } beat_t;

  beat_t sb_q[$];
  int    fcnt_q[$];
  beat_t got;
  int    total = 0;
  int    bad = 0;
  int    beats_seen = 0;
  int    done_seen = 0;
  int    guard_seen = 0;
  logic  tog = 1'b0;

  always #5 clk = ~clk;

  beam_mux_sched #(
    .N_BEAM_MUX_DACS(N),
    .SEL_W          (SEL_W),
    .CNT_W          (CNT_W),
    .GUARD_CYCLES   (GUARD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .dac_mask    (dac_mask),
    .dwell_frames(dwell_frames),
    .s_t_valid   (s_t_valid),
    .s_t_last    (s_t_last),
    .s_t_ready   (s_t_ready),
    .mux_t_ready (mux_t_ready),
    .mux_t_valid (mux_t_valid),
    .dac_sel     (dac_sel),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DAC-side monitor: every handshake must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (mux_t_valid && mux_t_ready) begin
      beats_seen++;
      check_output("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        got = sb_q.pop_front();
        check_output("beat_dac", 32'(dac_sel), 32'(got.dac));
        check_output("beat_data", 32'(s_t_data), 32'(got.data));
      end
    end
    if (mux_t_valid) begin
      check_output("ready_mirror", 32'(s_t_ready), 32'(mux_t_ready));
    end
    if (frame_done === 1'b1) begin
      done_seen++;
      check_output("fcnt_nonempty", 32'(fcnt_q.size() > 0), 32'd1);
      if (fcnt_q.size() > 0) begin
        check_output("frame_cnt", 32'(frame_cnt), 32'(fcnt_q.pop_front()));
      end
    end
    if (busy && !s_t_ready && mux_t_ready) begin
      guard_seen++;
    end
  end

  task automatic apply_beat(input logic [15:0] d, input logic last, input logic [1:0] exp_dac);
    logic acc;
    s_t_valid = 1'b1;
    s_t_data  = d;
    s_t_last  = last;
    sb_q.push_back('{dac: exp_dac, data: d});
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = (s_t_ready === 1'b1);
      @(posedge clk);
      #1;
      if (tog) mux_t_ready = ~mux_t_ready;
    end
    check_output("beat_accept", 32'(acc), 32'd1);
  endtask

  task automatic apply_stimulus(input int nbeats, input int base, input logic [1:0] exp_dac,
                                input int exp_fcnt);
    fcnt_q.push_back(exp_fcnt);
    for (int j = 0; j < nbeats; j++) begin
      apply_beat(16'(base + j), (j == nbeats - 1), exp_dac);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    beats_seen = 0;
    done_seen  = 0;
    guard_seen = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values, with upstream valid high to prove the gating.
    s_t_valid = 1'b1;
    #12;
    check_output("rst_dac_sel", 32'(dac_sel), 32'd0);
    check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_s_ready", 32'(s_t_ready), 32'd0);
    check_output("rst_m_valid", 32'(mux_t_valid), 32'd0);
    check_output("rst_frame_done", 32'(frame_done), 32'd0);
    s_t_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(2);

    $display("[TB] all DACs, dwell 2");
    clear_counts();
    dac_mask = 3'b111;
    dwell_frames = 8'd2;
    en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      apply_stimulus(4, f * 4, 2'(f / 2), (f % 2 == 0) ? 1 : 0);
    end
    s_t_valid = 1'b0;
    s_t_last = 1'b0;
    wait_cycles(6);
    check_output("t1_guard_cycles", 32'(guard_seen), 32'd8);
    check_output("t1_frame_done", 32'(done_seen), 32'd6);
    check_output("t1_wrap_dac", 32'(dac_sel), 32'd0);
    en = 1'b0;
    wait_cycles(2);
    check_output("t1_idle_busy", 32'(busy), 32'd0);
    check_output("t1_idle_ready", 32'(s_t_ready), 32'd0);

    $display("[TB] mask 101, dwell 1");
    clear_counts();
    dac_mask = 3'b101;
    dwell_frames = 8'd1;
    en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      apply_stimulus(3, 100 + f * 3, (f % 2 == 0) ? 2'd0 : 2'd2, 0);
    end
    s_t_valid = 1'b0;
    s_t_last = 1'b0;
    wait_cycles(6);
    check_output("t2_guard_cycles", 32'(guard_seen), 32'd10);
    check_output("t2_frame_done", 32'(done_seen), 32'd4);
    check_output("t2_wrap_dac", 32'(dac_sel), 32'd0);
    en = 1'b0;
    wait_cycles(2);

    $display("[TB] single DAC");
    clear_counts();
    dac_mask = 3'b010;
    dwell_frames = 8'd1;
    en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      apply_stimulus(4, 200 + f * 4, 2'd1, 0);
    end
    s_t_valid = 1'b0;
    s_t_last = 1'b0;
    wait_cycles(4);
    check_output("t3_guard_cycles", 32'(guard_seen), 32'd2);
    check_output("t3_frame_done", 32'(done_seen), 32'd3);
    check_output("t3_frame_cnt", 32'(frame_cnt), 32'd0);
    check_output("t3_dac", 32'(dac_sel), 32'd1);
    en = 1'b0;
    wait_cycles(2);

    $display("[TB] en dropped mid-frame");
    clear_counts();
    dac_mask = 3'b111;
    dwell_frames = 8'd1;
    en = 1'b1;
    fcnt_q.push_back(0);
    apply_beat(16'd300, 1'b0, 2'd0);
    en = 1'b0;
    apply_beat(16'd301, 1'b0, 2'd0);
    apply_beat(16'd302, 1'b0, 2'd0);
    apply_beat(16'd303, 1'b1, 2'd0);
    s_t_last = 1'b0;
    s_t_data = 16'hdead;
    check_output("t4_busy", 32'(busy), 32'd0);
    check_output("t4_s_ready", 32'(s_t_ready), 32'd0);
    check_output("t4_m_valid", 32'(mux_t_valid), 32'd0);
    check_output("t4_done_pulse", 32'(frame_done), 32'd1);
    wait_cycles(1);
    check_output("t4_done_clear", 32'(frame_done), 32'd0);
    s_t_valid = 1'b0;
    wait_cycles(2);
    check_output("t4_frame_done", 32'(done_seen), 32'd1);
    check_output("t4_beats", 32'(beats_seen), 32'd4);

    $display("[TB] toggling mux_t_ready, 1024 beats");
    clear_counts();
    dac_mask = 3'b111;
    dwell_frames = 8'd4;
    en = 1'b1;
    tog = 1'b1;
    for (int f = 0; f < 64; f++) begin
      apply_stimulus(16, f * 16, 2'((f / 4) % 3), (f % 4 == 3) ? 0 : (f % 4) + 1);
    end
    tog = 1'b0;
    mux_t_ready = 1'b1;
    s_t_valid = 1'b0;
    s_t_last = 1'b0;
    wait_cycles(8);
    check_output("t5_beats", 32'(beats_seen), 32'd1024);
    check_output("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    check_output("t5_frame_done", 32'(done_seen), 32'd64);
    en = 1'b0;
    wait_cycles(2);

    $display("[TB] async reset mid-frame");
    clear_counts();
    dac_mask = 3'b111;
    dwell_frames = 8'd1;
    en = 1'b1;
    apply_stimulus(4, 400, 2'd0, 0);
    apply_beat(16'd410, 1'b0, 2'd1);
    apply_beat(16'd411, 1'b0, 2'd1);
    s_t_data = 16'd412;
    check_output("t6_pre_dac", 32'(dac_sel), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_output("t6_rst_dac", 32'(dac_sel), 32'd0);
    check_output("t6_rst_busy", 32'(busy), 32'd0);
    check_output("t6_rst_s_ready", 32'(s_t_ready), 32'd0);
    check_output("t6_rst_m_valid", 32'(mux_t_valid), 32'd0);
    check_output("t6_rst_fcnt", 32'(frame_cnt), 32'd0);
    s_t_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(4, 500, 2'd0, 0);
    s_t_valid = 1'b0;
    s_t_last = 1'b0;
    wait_cycles(4);
    check_output("t6_sb_empty", 32'(sb_q.size()), 32'd0);
    check_output("t6_fcnt_empty", 32'(fcnt_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
